// File: rtl/counter_seq.sv
// Control sequencer for an external N-bit counter: prescaled tick, start/stop/pause, load and done.
// Optional feature: define COUNTER_SEQ_AUTO_RELOAD_EN to reload d_in and restart automatically after done.
module counter_seq #(
    parameter int unsigned N   = 6,
    parameter int unsigned DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         load_req,
    input  logic [N-1:0] d_in,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_load,
    output logic [N-1:0] cnt_d,
    output logic         busy,
    output logic         done,
    output logic [2:0]   state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] PRESC_TOP = 32'(DIV - 1);

    state_t      state;
    logic [31:0] presc;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    logic        auto_ld;
`endif

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
            auto_ld  <= 1'b0;
`endif
        end else begin
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            done     <= 1'b0;
            if (load_req) begin
                state    <= LOAD;
                presc    <= '0;
                cnt_load <= 1'b1;
                cnt_d    <= d_in;
                busy     <= 1'b0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                auto_ld  <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (start && !stop) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        presc <= '0;
                        state <= IDLE;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                        auto_ld <= 1'b0;
                        if (auto_ld) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                    RUN: begin
                        // stop wins over a coinciding tick; the prescaler keeps its count for resume
                        if (stop) begin
                            state <= PAUSE;
                        end else if (presc == PRESC_TOP) begin
                            presc <= '0;
                            if (cnt_q == limit) begin
                                done  <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                cnt_en <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) state <= RUN;
                    end
                    DONE: begin
                        presc <= '0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                        state    <= LOAD;
                        cnt_load <= 1'b1;
                        cnt_d    <= d_in;
                        auto_ld  <= 1'b1;
`else
                        if (start && !stop) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Testbench for counter_seq: directed scenarios plus random stimulus against a countdown-based model.
module tb_counter_seq;

    localparam int N   = 6;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         load_req = 1'b0;
    logic [N-1:0] d_in = '0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] cnt_q = '0;
    logic         cnt_en;
    logic         cnt_load;
    logic [N-1:0] cnt_d;
    logic         busy;
    logic         done;
    logic [2:0]   state_o;

    counter_seq #(.N(N), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load_req(load_req),
        .d_in(d_in), .limit(limit), .cnt_q(cnt_q),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_d(cnt_d),
        .busy(busy), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: mode uses the published state codes, rem = RUN cycles left until the next tick
    int           m_mode = 0;
    int           m_rem  = DIV;
    logic         m_en = 1'b0, m_ld = 1'b0, m_dn = 1'b0, m_auto = 1'b0;
    logic [N-1:0] m_d = '0;

    int n_chk = 0, n_pass = 0;
    int n_en = 0, n_dn = 0, n_ld = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step();
        m_en = 1'b0; m_ld = 1'b0; m_dn = 1'b0;
        if (rst) begin
            m_mode = 0; m_rem = DIV; m_d = '0; m_auto = 1'b0;
        end else if (load_req) begin
            m_mode = 1; m_ld = 1'b1; m_d = d_in; m_rem = DIV; m_auto = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    m_rem = DIV;
                    if (start && !stop) m_mode = 2;
                end
                1: begin
                    m_rem = DIV;
                    m_mode = m_auto ? 2 : 0;
                    m_auto = 1'b0;
                end
                2: begin
                    if (stop) m_mode = 3;
                    else if (m_rem == 1) begin
                        m_rem = DIV;
                        if (cnt_q == limit) begin m_dn = 1'b1; m_mode = 4; end
                        else m_en = 1'b1;
                    end else m_rem = m_rem - 1;
                end
                3: if (start && !stop) m_mode = 2;
                default: begin
                    m_rem = DIV;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                    m_mode = 1; m_ld = 1'b1; m_d = d_in; m_auto = 1'b1;
`else
                    if (start && !stop) m_mode = 2;
`endif
                end
            endcase
        end
    endtask

    // One clock: model advances on the edge, bench counter follows the pulses, outputs compared after
    task automatic cycle();
        logic         old_en, old_ld;
        logic [N-1:0] old_d;
        @(posedge clk);
        old_en = m_en; old_ld = m_ld; old_d = m_d;
        model_step();
        #1;
        if (old_ld) cnt_q = old_d;
        else if (old_en) cnt_q = cnt_q + 6'd1;
        n_en += int'(m_en); n_dn += int'(m_dn); n_ld += int'(m_ld);
        chk("cnt_en", cnt_en, m_en);
        chk("cnt_load", cnt_load, m_ld);
        chk("cnt_d", cnt_d, m_d);
        chk("done", done, m_dn);
        chk("busy", busy, (m_mode == 2 || m_mode == 3));
        chk("state_o", state_o, m_mode);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [N-1:0] d, input logic [N-1:0] lim);
        d_in = d; limit = lim; load_req = 1'b1;
        cycle();
        load_req = 1'b0;
        cycle();
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int k;
        logic [N-1:0] q[$];
        logic [N-1:0] prev;

        // reset state
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_cnt_d", cnt_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_o, 0);

        // basic run: 5 -> 8, three increments then done on the 4th tick
        do_load(6'd5, 6'd8);
        chk("ld_cntq", cnt_q, 5);
        n_en = 0; n_dn = 0;
        do_start();
        run(20);
        chk("basic_incs", n_en, 3);
        chk("basic_dones", n_dn, 1);
        chk("basic_cntq", cnt_q, 8);
`ifndef COUNTER_SEQ_AUTO_RELOAD_EN
        chk("basic_state", state_o, 4);
`endif

        // pause mid-count and resume with the remaining prescaler cycles
        do_load(6'd0, 6'd20);
        n_en = 0;
        do_start();
        run(5);
        chk("pre_pause_incs", n_en, 1);
        stop = 1'b1; n_en = 0;
        run(10);
        chk("pause_incs", n_en, 0);
        chk("pause_state", state_o, 3);
        stop = 1'b0;
        do_start();
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            cycle();
            if (cnt_en) k = i;
        end
        chk("resume_latency", k, 3);

        // wrap through 2^N-1 -> 0 and stop at limit
        do_load(6'd62, 6'd1);
        n_en = 0; n_dn = 0;
        do_start();
        q.delete();
        q.push_back(cnt_q);
        prev = cnt_q;
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (cnt_q != prev) begin q.push_back(cnt_q); prev = cnt_q; end
        end
        chk("wrap_len", q.size(), 4);
        chk("wrap_q0", (q.size() > 0) ? 32'(q[0]) : 32'd999, 62);
        chk("wrap_q1", (q.size() > 1) ? 32'(q[1]) : 32'd999, 63);
        chk("wrap_q2", (q.size() > 2) ? 32'(q[2]) : 32'd999, 0);
        chk("wrap_q3", (q.size() > 3) ? 32'(q[3]) : 32'd999, 1);
        chk("wrap_incs", n_en, 3);
        chk("wrap_dones", n_dn, 1);

        // load_req beats start in RUN
        do_load(6'd9, 6'd40);
        do_start();
        run(2);
        load_req = 1'b1; start = 1'b1; d_in = 6'd17;
        cycle();
        chk("ldwin_load", cnt_load, 1);
        chk("ldwin_d", cnt_d, 17);
        chk("ldwin_state", state_o, 1);
        load_req = 1'b0; start = 1'b0;
        cycle();
        chk("ldwin_idle", state_o, 0);

        // rst with the prescaler at DIV-1 cancels the pending tick
        do_start();
        run(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstrun_en", cnt_en, 0);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_state", state_o, 0);
        chk("rstrun_d", cnt_d, 0);
        cycle();
        chk("rstrun_en2", cnt_en, 0);
        chk("rstrun_done2", done, 0);

        // terminal count behaviour with and without auto reload
        do_load(6'd0, 6'd2);
        n_dn = 0; n_ld = 0;
        do_start();
        run(40);
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
        chk("auto_dones", n_dn >= 2, 1);
        chk("auto_loads", n_ld >= 2, 1);
`else
        chk("single_done", n_dn, 1);
        chk("single_loads", n_ld, 0);
        chk("single_state", state_o, 4);
`endif

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            load_req = ($urandom_range(0, 29) == 0);
            stop     = ($urandom_range(0, 7) == 0);
            start    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) begin
                d_in  = 6'($urandom_range(0, 63));
                limit = d_in + 6'($urandom_range(0, 4));
            end
            cycle();
        end
        rst = 1'b0; load_req = 1'b0; stop = 1'b0; start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 Parameter N, default 6, width of the controlled counter and of all count buses.
REQ-002 Parameter DIV, default 50_000_000, clk cycles per count tick; legal range 2..2^32-1.
REQ-003 clk  in  1  clock; every flop samples on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  level; begin or resume counting.
REQ-006 stop  in  1  level; pause counting.
REQ-007 load_req  in  1  level; load start value d_in and return to IDLE.
REQ-008 d_in  in  N  start value.
REQ-009 limit  in  N  terminal count.
REQ-010 cnt_q  in  N  feedback from the counter output.
REQ-011 cnt_en  out  1  one-cycle increment pulse to the counter.
REQ-012 cnt_load  out  1  one-cycle load pulse to the counter.
REQ-013 cnt_d  out  N  value to load; equals d_in registered when cnt_load is issued.
REQ-014 busy  out  1  high in RUN or PAUSE.
REQ-015 done  out  1  one-cycle pulse on terminal count.
REQ-016 state_o  out  3  encoded FSM state: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-018 Input priority each cycle SHALL be rst > load_req > stop > start.
REQ-019 load_req in any state SHALL go to LOAD next cycle; LOAD SHALL assert cnt_load for exactly 1 cycle with cnt_d=d_in, then go to IDLE.
REQ-020 IDLE + start -> RUN; RUN + stop -> PAUSE; PAUSE + start (stop low) -> RUN; DONE + start -> RUN.
REQ-021 The prescaler SHALL count 0..DIV-1 only in RUN, hold its value in PAUSE, and clear in IDLE, LOAD and DONE.
REQ-022 A tick SHALL occur in the RUN cycle where the prescaler equals DIV-1; the prescaler then wraps to 0.
REQ-023 On a tick with cnt_q != limit, cnt_en SHALL pulse high for 1 cycle, registered (the cycle after the tick).
REQ-024 On a tick with cnt_q == limit, there SHALL be no cnt_en; done SHALL pulse 1 cycle; the FSM SHALL go to DONE.
REQ-025 If d_in > limit, counting SHALL wrap through 2^N-1 -> 0 (counter native wrap) and stop at limit.
REQ-026 If d_in == limit, done SHALL fire on the first tick with zero increments.
REQ-027 stop asserted in the same cycle as a tick SHALL suppress that tick's cnt_en/done.
REQ-028 cnt_en and cnt_load SHALL never be high in the same cycle.
REQ-029 The limit compare SHALL use cnt_q sampled in the tick cycle; DIV>=2 guarantees the increment has landed before the next compare.

Reset
REQ-030 rst SHALL force state IDLE, prescaler 0, cnt_en=0, cnt_load=0, cnt_d=0, busy=0, done=0, state_o=0 at the next clk edge.
REQ-031 rst asserted mid-RUN SHALL cancel any pending cnt_en/done; the block SHALL NOT reset the counter itself.

Configuration
REQ-032 Macro COUNTER_SEQ_AUTO_RELOAD_EN: when defined, terminal count SHALL pulse done, then go to LOAD (cnt_load with d_in), then RUN automatically without start; when undefined, the FSM SHALL stay in DONE until start or load_req.

Verification
REQ-033 N=6, DIV=4, d_in=5, limit=8: load_req, then start -> cnt_en every 4 cycles; 3 increments; done at the 4th tick; state_o=4.
REQ-034 Start then stop held 10 cycles mid-count -> no cnt_en during the pause; on resume the first cnt_en arrives after the remaining prescaler cycles, not after a full DIV.
REQ-035 d_in=62, limit=1 -> cnt_q sequence 62,63,0,1; done after the 3rd increment.
REQ-036 load_req and start asserted together in RUN -> LOAD wins; cnt_load pulse with cnt_d=d_in; then state IDLE.
REQ-037 rst pulse in RUN with the prescaler at DIV-1 -> no cnt_en follows; all outputs 0 on the next cycle.
REQ-038 With COUNTER_SEQ_AUTO_RELOAD_EN, d_in=0, limit=2 -> periodic done, cnt_load, restart with no start input; without the macro -> a single done, then idle in DONE.
